// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the address-fault decode helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DWORD_BYTES = 8;
  localparam int CNT_W       = 4;

  // Doubleword accesses must be 8-byte aligned and fall inside the array.
  function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] limit);
    return (addr[2:0] != 3'd0) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 64-bit storage with a registered read port.
// The read is read-before-write; the storage itself is never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem_r [DEPTH];
  logic [63:0] rdata_r;

  // Storage write and registered read of the addressed doubleword.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
    rdata_r <= mem_r[idx];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the MEM-stage data-memory interface: one doubleword
// load/store per handshake, answered after LATENCY wait cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam logic [63:0]      ADDR_LIMIT = 64'(DEPTH) * 64'(DWORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             write_r;
  logic [63:0]      addr_r;
  logic [63:0]      wdata_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic [63:0]      resp_rdata_r;
  logic             resp_error_r;
  logic             busy_r;

  logic             fire_s;
  logic             fault_s;
  logic             array_we_s;
  logic [IDX_W-1:0] array_idx_s;
  logic [63:0]      array_rdata_s;

  assign fire_s     = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});
  assign fault_s    = addr_fault(addr_r, ADDR_LIMIT);
  assign array_we_s = fire_s && write_r && !fault_s;

  // In IDLE the array reads the incoming address so that even a one-cycle
  // wait has the latched doubleword sitting in the read register at fire time.
  always_comb begin
    array_idx_s = addr_r[IDX_W+2:3];
    if (state_r == IDLE) begin
      array_idx_s = req_addr[IDX_W+2:3];
    end else begin
      array_idx_s = addr_r[IDX_W+2:3];
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (array_we_s),
    .idx   (array_idx_s),
    .wdata (wdata_r),
    .rdata (array_rdata_s)
  );

  // Request/response FSM with all interface outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      write_r      <= 1'b0;
      addr_r       <= 64'd0;
      wdata_r      <= 64'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_error_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r     <= req_write;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= CNT_LOAD;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            resp_valid_r <= 1'b1;
            resp_error_r <= fault_s;
            resp_rdata_r <= (write_r || fault_s) ? 64'd0 : array_rdata_s;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            resp_error_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= {CNT_W{1'b0}};
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 64'd0;
          resp_error_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_error = resp_error_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) driven with
// directed and random traffic, checked every cycle against a transaction model.
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 256;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [63:0] req_addr   [NI];
  logic [63:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [63:0] resp_rdata [NI];
  logic        resp_error [NI];
  logic        busy       [NI];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_error(resp_error[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_error(resp_error[1]), .busy(busy[1]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
    .clock(clock), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_error(resp_error[2]), .busy(busy[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // {req_ready, resp_valid, busy, resp_error, resp_rdata}
  function automatic logic [67:0] outs(input int i);
    return {req_ready[i], resp_valid[i], busy[i], resp_error[i], resp_rdata[i]};
  endfunction

  task automatic chk(input string name, input int i, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
    end
  endtask

  // Transaction-level model: memory image plus at most one outstanding request.
  logic [63:0] mmem  [NI][DEPTH];
  bit          pend  [NI];
  int          due   [NI];
  bit          m_w   [NI];
  bit          m_err [NI];
  int          m_idx [NI];
  logic [63:0] m_wd  [NI];
  logic [63:0] m_rd  [NI];

  initial begin
    for (int i = 0; i < NI; i++) pend[i] = 1'b0;
  end

  always @(negedge clock) begin
    logic [67:0] exp_v;
    logic [63:0] a;
    for (int i = 0; i < NI; i++) begin
      if (pend[i] && cyc == due[i] && m_w[i] && !m_err[i]) mmem[i][m_idx[i]] = m_wd[i];
      if (reset[i] || !pend[i])  exp_v = {4'b1000, 64'd0};
      else if (cyc < due[i])     exp_v = {4'b0010, 64'd0};
      else                       exp_v = {3'b011, m_err[i], m_rd[i]};
      chk("model", i, outs(i), exp_v);
      if (reset[i]) begin
        pend[i] = 1'b0;
      end else if (!pend[i]) begin
        if (req_valid[i]) begin
          a        = req_addr[i];
          pend[i]  = 1'b1;
          due[i]   = cyc + lat_of(i) + 1;
          m_w[i]   = req_write[i];
          m_wd[i]  = req_wdata[i];
          m_err[i] = (a % 64'd8 != 64'd0) || (a >= 64'(DEPTH * 8));
          m_idx[i] = m_err[i] ? 0 : int'(a / 64'd8);
          m_rd[i]  = (m_w[i] || m_err[i]) ? 64'd0 : mmem[i][m_idx[i]];
        end
      end else if (cyc >= due[i] && resp_ready[i]) begin
        pend[i] = 1'b0;
      end
    end
  end

  task automatic do_reset(input int i);
    @(posedge clock); #1 reset[i] = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_values", i, outs(i), {4'b1000, 64'd0});
    @(posedge clock); #1 reset[i] = 1'b0;
  endtask

  // One full transaction; request inputs are scrambled while it is in flight.
  task automatic xact(input int i, input bit w, input logic [63:0] a, input logic [63:0] d,
                      input bit bp, output int acc_c, output int rsp_c,
                      output logic [63:0] rd, output logic er);
    int n;
    rsp_c = -1; acc_c = -1; rd = 64'd0; er = 1'b0;
    @(posedge clock); #1;
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
    resp_ready[i] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (req_ready[i]) break;
      n++;
      if (n > 64) begin chk("accept_timeout", i, 68'(req_ready[i]), 68'd1); break; end
    end
    acc_c = cyc;
    @(posedge clock); #1 req_valid[i] = 1'b0;
    n = 0;
    forever begin
      @(negedge clock);
      if (resp_valid[i] && rsp_c < 0) begin rsp_c = cyc; rd = resp_rdata[i]; er = resp_error[i]; end
      if (resp_valid[i] && resp_ready[i]) break;
      n++;
      if (n > 100) begin chk("resp_timeout", i, 68'(resp_valid[i]), 68'd1); break; end
      @(posedge clock); #1;
      req_addr[i]   = {$urandom, $urandom};
      req_wdata[i]  = {$urandom, $urandom};
      resp_ready[i] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic prefill(input int i);
    int a, r; logic [63:0] rd; logic er;
    for (int k = 0; k < 16; k++) xact(i, 1'b1, 64'(k) * 64'd8, {$urandom, $urandom}, 1'b1, a, r, rd, er);
  endtask

  task automatic random_traffic(input int i, input int cnt);
    int a, r, sel; logic [63:0] rd, ad; logic er;
    for (int k = 0; k < cnt; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       ad = 64'($urandom_range(0, 15)) * 64'd8;
      else if (sel == 8) ad = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(1, 7));
      else               ad = 64'h800 + 64'($urandom_range(0, 1000)) * 64'd8;
      xact(i, 1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, 1'b1, a, r, rd, er);
      chk("rand_latency", i, 68'(r - a), 68'(lat_of(i) + 1));
    end
  endtask

  // Back-to-back loads with resp_ready tied high.
  task automatic sweep(input int i);
    int prev, last, got, n; bit acc;
    prev = -1; last = -1; got = 0; n = 0;
    @(posedge clock); #1;
    req_valid[i] = 1'b1; req_write[i] = 1'b0; resp_ready[i] = 1'b1;
    req_addr[i] = 64'($urandom_range(0, 15)) * 64'd8;
    while (got < 6 && n < 200) begin
      @(negedge clock);
      n++; acc = 1'b0;
      if (resp_valid[i]) begin chk("sweep_latency", i, 68'(cyc - last), 68'(lat_of(i) + 1)); got++; end
      if (req_valid[i] && req_ready[i]) begin
        if (prev >= 0) chk("sweep_gap", i, 68'(cyc - prev), 68'(lat_of(i) + 2));
        prev = cyc; last = cyc; acc = 1'b1;
      end
      @(posedge clock); #1;
      if (acc) req_addr[i] = 64'($urandom_range(0, 15)) * 64'd8;
      if (got >= 6) req_valid[i] = 1'b0;
    end
    if (got < 6) chk("sweep_timeout", i, 68'(resp_valid[i]), 68'd1);
  endtask

  // Hand-computed expectations on the LATENCY=2 instance.
  task automatic directed();
    int a, r, n; logic [63:0] rd; logic er;
    xact(0, 1'b1, 64'h10, 64'hDEADBEEF00000001, 1'b0, a, r, rd, er);
    chk("store_latency", 0, 68'(r - a), 68'd3);
    chk("store_resp", 0, {er, rd}, {1'b0, 64'd0});
    xact(0, 1'b0, 64'h10, 64'd0, 1'b0, a, r, rd, er);
    chk("load_latency", 0, 68'(r - a), 68'd3);
    chk("load_resp", 0, {er, rd}, {1'b0, 64'hDEADBEEF00000001});
    xact(0, 1'b0, 64'h13, 64'd0, 1'b0, a, r, rd, er);
    chk("misaligned", 0, {er, rd}, {1'b1, 64'd0});
    chk("err_latency", 0, 68'(r - a), 68'd3);
    xact(0, 1'b1, 64'h0, 64'h0123456789ABCDEF, 1'b0, a, r, rd, er);
    xact(0, 1'b1, 64'h800, 64'hFFFFFFFFFFFFFFFF, 1'b0, a, r, rd, er);
    chk("range_store", 0, {er, rd}, {1'b1, 64'd0});
    xact(0, 1'b0, 64'h0, 64'd0, 1'b0, a, r, rd, er);
    chk("range_no_write", 0, {er, rd}, {1'b0, 64'h0123456789ABCDEF});
    xact(0, 1'b1, 64'h20, 64'hA5A5A5A55A5A5A5A, 1'b1, a, r, rd, er);

    @(posedge clock); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20; req_wdata[0] = 64'h55;
    resp_ready[0] = 1'b1;
    @(negedge clock);
    chk("midwait_accept", 0, 68'(req_ready[0]), 68'd1);
    @(posedge clock); #1 req_valid[0] = 1'b0;
    chk("midwait_busy", 0, outs(0), {4'b0010, 64'd0});
    #1 reset[0] = 1'b1;
    #1 chk("midwait_reset", 0, outs(0), {4'b1000, 64'd0});
    @(posedge clock); #1 reset[0] = 1'b0;
    xact(0, 1'b0, 64'h20, 64'd0, 1'b0, a, r, rd, er);
    chk("midwait_discard", 0, {er, rd}, {1'b0, 64'hA5A5A5A55A5A5A5A});

    @(posedge clock); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 64'h10; resp_ready[0] = 1'b0;
    @(negedge clock);
    chk("bp_accept", 0, 68'(req_ready[0]), 68'd1);
    @(posedge clock); #1;
    req_write[0] = 1'b1; req_addr[0] = 64'h18; req_wdata[0] = 64'hBAD;
    n = 0;
    forever begin
      @(negedge clock);
      if (resp_valid[0] || n > 40) break;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      chk("bp_hold", 0, outs(0), {4'b0110, 64'hDEADBEEF00000001});
    end
    @(posedge clock); #1 resp_ready[0] = 1'b1; req_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("bp_release", 0, outs(0), {4'b1000, 64'd0});

    xact(0, 1'b0, 64'h10, 64'hFFFF, 1'b0, a, r, rd, er);
    chk("input_stability", 0, {er, rd}, {1'b0, 64'hDEADBEEF00000001});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = 64'd0; req_wdata[i] = 64'd0; resp_ready[i] = 1'b0;
    end
    fork
      begin do_reset(0); prefill(0); directed();  random_traffic(0, 40); end
      begin do_reset(1); prefill(1); sweep(1);    random_traffic(1, 40); end
      begin do_reset(2); prefill(2); sweep(2);    random_traffic(2, 25); end
    join
    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
